// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: prioritised, maskable multi-source interrupt controller.
// Define INTC_SYNC_EN to add a 2-flop synchroniser on SRC_IN.
module otter_intr_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1120_0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC_IN,
  input  logic [31:0]        IOBUS_ADDR,
  input  logic [31:0]        IOBUS_OUT,
  input  logic               IOBUS_WR,
  output logic [31:0]        IOBUS_IN,
  output logic               INTR,
  input  logic               INT_TAKEN,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] INT_ID
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  localparam logic [3:0] OFF_PEND = 4'd0;
  localparam logic [3:0] OFF_EN   = 4'd1;
  localparam logic [3:0] OFF_EDGE = 4'd2;
  localparam logic [3:0] OFF_CLM  = 4'd3;
  localparam logic [3:0] OFF_CMP  = 4'd4;

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] s_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] active_req;
  logic [NUM_SRC-1:0] clr_mask;
  logic [NUM_SRC-1:0] w1c;

  logic [1:0]      state;
  logic            active_valid;
  logic [ID_W-1:0] winner;
  logic            any_req;

  logic [31:0] off;
  logic        hit;
  logic [3:0]  widx;
  logic        wr_pend;
  logic        wr_en;
  logic        wr_edge;
  logic        wr_cmp;
  logic        take;
  logic        cmp_ok;
  logic [31:0] claim_word;
  logic        unused_bits;

  assign unused_bits = ^IOBUS_OUT;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  // two-flop synchroniser for lines from other clock domains
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SRC_IN;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = SRC_IN;
`endif

  // delayed copy of the source view for rising-edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) s_d <= '0;
    else     s_d <= s;
  end

  assign rise = s & ~s_d;

  assign off  = IOBUS_ADDR - BASE_ADDR;
  assign hit  = (off < 32'd64);
  assign widx = off[5:2];

  assign wr_pend = IOBUS_WR && hit && (widx == OFF_PEND);
  assign wr_en   = IOBUS_WR && hit && (widx == OFF_EN);
  assign wr_edge = IOBUS_WR && hit && (widx == OFF_EDGE);
  assign wr_cmp  = IOBUS_WR && hit && (widx == OFF_CMP);

  assign active_req = pending & enable;
  assign any_req    = |active_req;

  // fixed priority: lowest enabled pending index wins
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_req[i]) winner = ID_W'(i);
    end
  end

  assign take   = (state == ST_REQ) && INT_TAKEN && any_req;
  assign cmp_ok = (state == ST_SVC) && wr_cmp &&
                  (IOBUS_OUT[ID_W-1:0] == INT_ID);

  assign clr_mask = take ? (NUM_SRC'(1) << winner) : '0;
  assign w1c      = wr_pend ? IOBUS_OUT[NUM_SRC-1:0] : '0;

  // edge bits: a new edge beats any clear in the same cycle;
  // level bits simply follow the synchronised line
  assign pending_n =
    (edge_mode & (rise | (pending & ~w1c & ~clr_mask))) |
    (~edge_mode & s);

  // pending latch
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pending <= '0;
    else     pending <= pending_n;
  end

  // software-programmed mask and mode registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enable    <= '0;
      edge_mode <= '0;
    end else begin
      if (wr_en)   enable    <= IOBUS_OUT[NUM_SRC-1:0];
      if (wr_edge) edge_mode <= IOBUS_OUT[NUM_SRC-1:0];
    end
  end

  // request / acknowledge / in-service sequencing
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      INTR         <= 1'b0;
      INT_ID       <= '0;
      active_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            INTR  <= 1'b1;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (take) begin
            INT_ID       <= winner;
            active_valid <= 1'b1;
            INTR         <= 1'b0;
            state        <= ST_SVC;
          end else if (!any_req) begin
            INTR  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SVC: begin
          if (cmp_ok) begin
            active_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          INTR         <= 1'b0;
          active_valid <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign claim_word = {active_valid, 31'(INT_ID)};

  // combinational register read-back
  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      unique case (1'b1)
        (widx == OFF_PEND): IOBUS_IN = 32'(pending);
        (widx == OFF_EN):   IOBUS_IN = 32'(enable);
        (widx == OFF_EDGE): IOBUS_IN = 32'(edge_mode);
        (widx == OFF_CLM):  IOBUS_IN = claim_word;
        default:            IOBUS_IN = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed and randomized checks of otter_intr_ctrl.
// A second 3-source instance covers register width bounds.
module tb_otter_intr_ctrl;

  localparam logic [31:0] BASE = 32'h1120_0000;
`ifdef INTC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src_in = '0;
  logic [2:0]  src3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic [31:0] rdata3;
  logic        intr;
  logic        intr3;
  logic        taken = 1'b0;
  logic        taken3 = 1'b0;
  logic [2:0]  int_id;
  logic [1:0]  id3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .CLK(clk), .RST(rst), .SRC_IN(src_in),
    .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
    .IOBUS_IN(rdata), .INTR(intr), .INT_TAKEN(taken),
    .INT_ID(int_id)
  );

  otter_intr_ctrl #(.NUM_SRC(3), .BASE_ADDR(BASE)) dut3 (
    .CLK(clk), .RST(rst), .SRC_IN(src3),
    .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
    .IOBUS_IN(rdata3), .INTR(intr3), .INT_TAKEN(taken3),
    .INT_ID(id3)
  );

  task automatic set_off(input logic [31:0] o);
    addr = BASE + o;
    #1;
  endtask

  task automatic bus_write(input logic [31:0] o,
                           input logic [31:0] d);
    @(negedge clk);
    addr = BASE + o;
    wdata = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic take_pulse;
    @(negedge clk);
    taken = 1'b1;
    @(negedge clk);
    taken = 1'b0;
  endtask

  task automatic wait_intr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (intr === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL rst_intr got=%b exp=0", intr);
    end
    checks++;
    if (int_id !== 3'd0) begin
      errors++;
      $display("FAIL rst_id got=%0d exp=0", int_id);
    end
    set_off(32'h0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_pend got=%h exp=0", rdata);
    end
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_claim got=%h exp=0", rdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_edge;
    bus_write(32'h8, 32'h1);
    bus_write(32'h4, 32'h1);
    @(negedge clk);
    src_in[0] = 1'b1;
    @(negedge clk);
    src_in[0] = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL edge_early got=%b exp=0", intr);
    end
    @(negedge clk);
    checks++;
    if (intr !== 1'b1) begin
      errors++;
      $display("FAIL edge_lat got=%b exp=1", intr);
    end
    set_off(32'h0);
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL edge_pend got=%h exp=1", rdata);
    end
    take_pulse();
    checks++;
    if (int_id !== 3'd0 || intr !== 1'b0) begin
      errors++;
      $display("FAIL edge_take id=%0d intr=%b exp id=0 intr=0",
               int_id, intr);
    end
    set_off(32'h0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL edge_pend_clr got=%h exp=0", rdata);
    end
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h8000_0000) begin
      errors++;
      $display("FAIL edge_claim got=%h exp=80000000", rdata);
    end
    bus_write(32'h10, 32'h0);
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL edge_complete got=%h exp=0", rdata);
    end
  endtask

  task automatic test_priority;
    bit ok;
    bus_write(32'h8, 32'h0);
    bus_write(32'h4, 32'h24);
    @(negedge clk);
    src_in = 8'h24;
    wait_intr(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL prio_intr got=%b exp=1", ok);
    end
    take_pulse();
    checks++;
    if (int_id !== 3'd2) begin
      errors++;
      $display("FAIL prio_first got=%0d exp=2", int_id);
    end
    bus_write(32'h10, 32'h2);
    @(negedge clk);
    src_in[2] = 1'b0;
    repeat (6) @(negedge clk);
    take_pulse();
    checks++;
    if (int_id !== 3'd5) begin
      errors++;
      $display("FAIL prio_second got=%0d exp=5", int_id);
    end
    bus_write(32'h10, 32'h5);
    @(negedge clk);
    src_in[5] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle got=%b exp=0", intr);
    end
  endtask

  task automatic test_mask;
    bit ok;
    bus_write(32'h4, 32'h8);
    @(negedge clk);
    src_in[3] = 1'b1;
    wait_intr(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL mask_intr got=%b exp=1", ok);
    end
    bus_write(32'h4, 32'h0);
    @(negedge clk);
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL mask_drop got=%b exp=0", intr);
    end
    set_off(32'h0);
    checks++;
    if (rdata !== 32'h8) begin
      errors++;
      $display("FAIL mask_pend got=%h exp=8", rdata);
    end
    take_pulse();
    set_off(32'hC);
    checks++;
    if (rdata[31] !== 1'b0) begin
      errors++;
      $display("FAIL mask_idle got=%b exp=0", rdata[31]);
    end
    src_in[3] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_wrong_complete;
    bit ok;
    bus_write(32'h8, 32'h2);
    bus_write(32'h4, 32'h2);
    @(negedge clk);
    src_in[1] = 1'b1;
    @(negedge clk);
    src_in[1] = 1'b0;
    wait_intr(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL wc_intr got=%b exp=1", ok);
    end
    take_pulse();
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h8000_0001) begin
      errors++;
      $display("FAIL wc_claim got=%h exp=80000001", rdata);
    end
    bus_write(32'h10, 32'h4);
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h8000_0001) begin
      errors++;
      $display("FAIL wc_ignored got=%h exp=80000001", rdata);
    end
    @(negedge clk);
    src_in[1] = 1'b1;
    repeat (LAT - 2) @(negedge clk);
    addr = BASE;
    wdata = 32'h2;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    set_off(32'h0);
    checks++;
    if (rdata !== 32'h2) begin
      errors++;
      $display("FAIL set_vs_w1c got=%h exp=2", rdata);
    end
    bus_write(32'h0, 32'h2);
    bus_write(32'h10, 32'h1);
    src_in[1] = 1'b0;
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL wc_complete got=%h exp=1", rdata);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random_arb;
    bit ok;
    logic [7:0] en;
    logic [7:0] lv;
    logic [7:0] m;
    logic [7:0] low;
    int exp_id;
    bus_write(32'h8, 32'h0);
    for (int it = 0; it < 8; it++) begin
      en = 8'($urandom);
      lv = 8'($urandom);
      if ((en & lv) == 8'h0) begin
        en[it] = 1'b1;
        lv[it] = 1'b1;
      end
      m = en & lv;
      low = m & (~m + 8'd1);
      exp_id = $clog2(low);
      bus_write(32'h4, 32'(en));
      @(negedge clk);
      src_in = lv;
      wait_intr(ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL rnd_intr it=%0d got=%b exp=1", it, ok);
      end
      take_pulse();
      checks++;
      if (int_id !== 3'(exp_id)) begin
        errors++;
        $display("FAIL rnd_id en=%h lv=%h got=%0d exp=%0d",
                 en, lv, int_id, exp_id);
      end
      set_off(32'hC);
      checks++;
      if (rdata !== (32'h8000_0000 | 32'(exp_id))) begin
        errors++;
        $display("FAIL rnd_claim got=%h exp=%h", rdata,
                 32'h8000_0000 | 32'(exp_id));
      end
      bus_write(32'h10, 32'(exp_id));
      @(negedge clk);
      src_in = '0;
      bus_write(32'h4, 32'h0);
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_random_edge;
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] w;
    bus_write(32'h4, 32'h0);
    bus_write(32'h8, 32'hFF);
    acc = '0;
    for (int it = 0; it < 6; it++) begin
      p = 8'($urandom);
      @(negedge clk);
      src_in = p;
      @(negedge clk);
      src_in = '0;
      repeat (LAT + 2) @(negedge clk);
      acc = acc | p;
      set_off(32'h0);
      checks++;
      if (rdata !== 32'(acc)) begin
        errors++;
        $display("FAIL redge_set got=%h exp=%h", rdata, acc);
      end
      w = 8'($urandom);
      bus_write(32'h0, 32'(w));
      acc = acc & ~w;
      set_off(32'h0);
      checks++;
      if (rdata !== 32'(acc)) begin
        errors++;
        $display("FAIL redge_w1c got=%h exp=%h", rdata, acc);
      end
    end
    bus_write(32'h0, 32'hFF);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus_write(32'h8, 32'h1);
    bus_write(32'h4, 32'h1);
    @(negedge clk);
    src_in[0] = 1'b1;
    @(negedge clk);
    src_in[0] = 1'b0;
    wait_intr(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rmid_intr got=%b exp=1", ok);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async got=%b exp=0", intr);
    end
    set_off(32'h0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rmid_pend got=%h exp=0", rdata);
    end
    set_off(32'h4);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rmid_en got=%h exp=0", rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    take_pulse();
    set_off(32'hC);
    checks++;
    if (rdata !== 32'h0 || intr !== 1'b0) begin
      errors++;
      $display("FAIL rmid_idle claim=%h intr=%b exp 0/0",
               rdata, intr);
    end
  endtask

  task automatic test_bounds;
    bus_write(32'h4, 32'hFFFF_FFFF);
    set_off(32'h4);
    checks++;
    if (rdata3 !== 32'h7) begin
      errors++;
      $display("FAIL bnd_en3 got=%h exp=7", rdata3);
    end
    checks++;
    if (rdata !== 32'hFF) begin
      errors++;
      $display("FAIL bnd_en8 got=%h exp=ff", rdata);
    end
    bus_write(32'h8, 32'hFFFF_FFFF);
    set_off(32'h8);
    checks++;
    if (rdata3 !== 32'h7) begin
      errors++;
      $display("FAIL bnd_edge3 got=%h exp=7", rdata3);
    end
    set_off(32'h14);
    checks++;
    if (rdata3 !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL bnd_unmapped got=%h/%h exp=0", rdata3, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_priority();
    test_mask();
    test_wrong_complete();
    test_random_arb();
    test_random_edge();
    test_reset_mid();
    test_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Parametrised multi-source interrupt controller for the OTTER MCU; replaces the single INTR pin with NUM_SRC prioritised, maskable sources.
- Sits between peripheral interrupt lines and the CSU FSM INTR input; exchanges a request/acknowledge handshake with the FSM's INT_TAKEN.
- Programmed over the IOBUS as memory-mapped registers at BASE_ADDR.
- Tracks one in-service interrupt until software writes COMPLETE.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32); ID_W = max(1, $clog2(NUM_SRC))
- BASE_ADDR, 32'h1120_0000, IOBUS base address of the register block (16-byte aligned)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- SRC_IN  in  NUM_SRC  raw interrupt lines from peripherals
- IOBUS_ADDR  in  32  bus address (ALU_OUT)
- IOBUS_OUT  in  32  bus write data (RS2)
- IOBUS_WR  in  1  bus write strobe
- IOBUS_IN  out  32  read data, combinational from IOBUS_ADDR
- INTR  out  1  registered request to CSU FSM (gated there by CSR_MIE)
- INT_TAKEN  in  1  one-cycle acknowledge from CSU FSM
- INT_ID  out  ID_W  ID of the in-service source

Behaviour:
- Reset (async, RST=1): PENDING, ENABLE, EDGE, INT_ID, ACTIVE_VALID = 0; state IDLE; INTR = 0; synchroniser flops = 0.
- Register map (offset from BASE_ADDR; word access; unmapped offsets in the 16-word window read 0; writes to them are ignored):
  - 0x00 PENDING: RO view. W1C clears edge-mode bits only.
  - 0x04 ENABLE: RW mask.
  - 0x08 EDGE: RW; 1 = rising-edge source, 0 = level source.
  - 0x0C CLAIM: RO; bit31 = ACTIVE_VALID, bits[ID_W-1:0] = INT_ID.
  - 0x10 COMPLETE: WO; write data[ID_W-1:0] = ID being completed.
- Bits at or above NUM_SRC read 0; writes to them are ignored.
- Source path: SRC_IN goes through a 2-flop synchroniser to S, with a delay flop S_D.
  - Edge source: pending bit is set on the cycle after S & ~S_D.
  - Level source: pending bit = S, re-evaluated every cycle.
  - Set has priority over a W1C write or a claim-clear in the same cycle.
- Selection: lowest index with PENDING & ENABLE wins. Fixed priority; bit 0 is highest.
- FSM:
  - IDLE: if any PENDING & ENABLE, then INTR <= 1 and go to REQ.
  - REQ: INTR held at 1.
    - If INT_TAKEN: latch INT_ID = current winner, set ACTIVE_VALID, clear that pending bit if it is edge-mode, INTR <= 0, go to IN_SERVICE.
    - If the request vanishes first (masked, W1C, or level dropped), INTR <= 0 and go to IDLE.
  - IN_SERVICE: INTR = 0; new pendings accumulate.
    - A COMPLETE write with data == INT_ID clears ACTIVE_VALID and goes to IDLE.
    - A COMPLETE write with a mismatched ID is ignored.
- INTR latency: edge at SRC_IN to INTR high = 4 CLK edges (2 sync, 1 pending, 1 INTR register).
- INT_TAKEN outside REQ is ignored.
- A COMPLETE write outside IN_SERVICE is ignored.
- Disabling ENABLE for the in-service source does not abort service.
- Reset mid-service returns the block to IDLE with everything cleared. No pending state survives reset.

Optional Feature:
- INTC_SYNC_EN.
  - Defined: 2-flop input synchroniser present, as above.
  - Undefined: SRC_IN feeds S directly (sources must already be synchronous to CLK), and edge-to-INTR latency drops to 2 edges.
  - All other behaviour is identical.

Test Plan:
- Reset check: assert RST mid-REQ. Required: INTR=0; PENDING, ENABLE and CLAIM read 0; state IDLE within the same cycle (asynchronous).
- Edge source path:
  - Setup: EDGE=0x01, ENABLE=0x01.
  - Stimulus: pulse SRC_IN[0] high for 1 cycle.
  - Required: INTR rises 4 edges later, PENDING=0x1.
  - Stimulus: INT_TAKEN pulse.
  - Required: INT_ID=0, PENDING=0x0, CLAIM=0x8000_0000, INTR=0.
  - Stimulus: write 0 to COMPLETE.
  - Required: CLAIM=0.
- Priority:
  - Setup: level sources 2 and 5 both high, ENABLE=0x24.
  - Stimulus: INT_TAKEN.
  - Required: INT_ID=2.
  - Stimulus: COMPLETE(2), then deassert SRC_IN[2].
  - Required: next INT_TAKEN gives INT_ID=5.
- Masking and level drop:
  - Setup: level source 3, ENABLE=0x08.
  - Stimulus: raise SRC_IN[3] until INTR=1, then clear ENABLE before INT_TAKEN.
  - Required: INTR=0 next cycle, FSM IDLE, PENDING bit 3 still 1.
- Wrong completion and simultaneous events:
  - Stimulus: in IN_SERVICE with INT_ID=1, write COMPLETE=4.
  - Required: CLAIM is unchanged.
  - Stimulus: rising edge on source 1 in the same cycle as a W1C of 0x02.
  - Required: PENDING bit 1 = 1.
- Bounds:
  - Setup: NUM_SRC=3.
  - Stimulus: write ENABLE=0xFFFF_FFFF.
  - Required: reads back 0x7.
  - Stimulus: read offset 0x14.
  - Required: returns 0.
